// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - register-writeback trace FIFO with shadow register bank
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0,
    parameter int CYC_W  = 32,
    localparam int IDX_W = $clog2(NREG),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CYC_W-1:0]  rd_cycle,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       dropped,
    input  logic [IDX_W-1:0]  snap_idx,
    output logic [DATA_W-1:0] snap_data
);

    localparam bit WRAP_EN = (WRAP != 0);

    logic [DATA_W-1:0] mem_pc   [DEPTH];
    logic [IDX_W-1:0]  mem_idx  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CYC_W-1:0]  mem_cyc  [DEPTH];
    logic [DATA_W-1:0] shadow   [NREG];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CYC_W-1:0] cyc;

    logic cap;
    logic pop;
    logic is_full;
    logic lost;
    logic wr_en;
    logic rd_adv;

    // Decode this edge's push/pop/drop; a simultaneous pop frees the slot of a full FIFO.
    always_comb begin
        cap     = wb_valid & en & (wb_rd != '0);
        pop     = (cnt != '0) & rd_ready;
        is_full = (cnt == CNT_W'(DEPTH));
        lost    = cap & is_full & ~pop;
        wr_en   = cap & (~is_full | pop | WRAP_EN);
        rd_adv  = pop | (lost & WRAP_EN);
    end

    // Pointers, occupancy, cycle stamp and loss bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            cyc      <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            if (en) begin
                cyc <= cyc + CYC_W'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_adv) begin
                cnt <= cnt + CNT_W'(1);
            end else if (rd_adv && !wr_en) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (lost) begin
                overflow <= 1'b1;
                if (dropped != 16'hFFFF) begin
                    dropped <= dropped + 16'd1;
                end
            end
        end
    end

    // Entry storage; contents are don't-care until the slot is written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= wb_pc;
            mem_idx[wr_ptr]  <= wb_rd;
            mem_data[wr_ptr] <= wb_data;
            mem_cyc[wr_ptr]  <= cyc;
        end
    end

    // Shadow register bank follows every capture, whether or not the FIFO kept it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
            end
        end else if (cap) begin
            shadow[wb_rd] <= wb_data;
        end
    end

    // Head entry is driven from storage only, masked to zero while empty.
    always_comb begin
        rd_valid  = (cnt != '0);
        rd_pc     = rd_valid ? mem_pc[rd_ptr]   : '0;
        rd_idx    = rd_valid ? mem_idx[rd_ptr]  : '0;
        rd_data   = rd_valid ? mem_data[rd_ptr] : '0;
        rd_cycle  = rd_valid ? mem_cyc[rd_ptr]  : '0;
        count     = cnt;
        full      = is_full;
        snap_data = shadow[snap_idx];
    end

endmodule
